// File: rtl/robo_pkg.sv
// Shared definitions for the robot-maze goal detection blocks:
// FSM state encodings and the VGA colour codes driven toward the colour mux.
package robo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DWELL   = 2'd1,
      ST_REACHED = 2'd2
   } state_t;

   localparam logic [2:0] COL_OUTSIDE = 3'b111;
   localparam logic [2:0] COL_INZONE  = 3'b000;
   localparam logic [2:0] COL_REACHED = 3'b010;

endpackage

// File: rtl/zone_compare.sv
// Combinational single-rectangle hit test, inclusive unsigned bounds.
// An inverted rectangle (min > max) can never satisfy both comparisons.
module zone_compare #(
   parameter int COORD_W = 9
) (
   input  logic               i_en,
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   input  logic [COORD_W-1:0] i_x_min,
   input  logic [COORD_W-1:0] i_x_max,
   input  logic [COORD_W-1:0] i_y_min,
   input  logic [COORD_W-1:0] i_y_max,
   output logic               o_hit
);

   assign o_hit = i_en
                & (i_x >= i_x_min) & (i_x <= i_x_max)
                & (i_y >= i_y_min) & (i_y <= i_y_max);

endmodule

// File: rtl/goal_zone_detector.sv
// Multi-zone goal detector: registers per-zone hits of each valid sample, tracks
// a dwell run on the lowest-index hit zone and latches a goal-reached event.
module goal_zone_detector
   import robo_pkg::*;
#(
   parameter int COORD_W       = 9,
   parameter int NUM_ZONES     = 4,
   parameter int DWELL_SAMPLES = 8,
   parameter int ZIDX_W        = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         coord_valid,
   input  logic [COORD_W-1:0]           x_cord,
   input  logic [COORD_W-1:0]           y_cord,
   input  logic [NUM_ZONES-1:0]         zone_en,
   input  logic [NUM_ZONES*COORD_W-1:0] zone_x_min,
   input  logic [NUM_ZONES*COORD_W-1:0] zone_x_max,
   input  logic [NUM_ZONES*COORD_W-1:0] zone_y_min,
   input  logic [NUM_ZONES*COORD_W-1:0] zone_y_max,
   input  logic                         clear,
   output logic [NUM_ZONES-1:0]         zone_hit,
   output logic [2:0]                   colour,
   output logic                         goal_reached,
   output logic [ZIDX_W-1:0]            reached_zone
);

   localparam int CNT_W = $clog2(DWELL_SAMPLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DWELL_SAMPLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_SAMPLES - 1);

   logic [NUM_ZONES-1:0] w_hit;
   logic [NUM_ZONES-1:0] r_zone_hit;
   logic                 r_eval;
   logic [ZIDX_W-1:0]    w_sel;
   logic                 w_any;
   logic                 w_trk_hit;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [ZIDX_W-1:0]    r_trk_zone;
   logic [ZIDX_W-1:0]    w_trk_nxt;
   logic [ZIDX_W-1:0]    r_reached_zone;

   for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_zone
      zone_compare #(.COORD_W(COORD_W)) u_cmp (
         .i_en    (zone_en[gi]),
         .i_x     (x_cord),
         .i_y     (y_cord),
         .i_x_min (zone_x_min[gi*COORD_W +: COORD_W]),
         .i_x_max (zone_x_max[gi*COORD_W +: COORD_W]),
         .i_y_min (zone_y_min[gi*COORD_W +: COORD_W]),
         .i_y_max (zone_y_max[gi*COORD_W +: COORD_W]),
         .o_hit   (w_hit[gi])
      );
   end

   // A sample taken together with clear is registered but never evaluated by the FSM.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_zone_hit <= '0;
         r_eval     <= 1'b0;
      end else begin
         if (coord_valid) r_zone_hit <= w_hit;
         r_eval <= coord_valid & ~clear;
      end
   end

   always_comb begin
      w_sel = '0;
      for (int i = NUM_ZONES - 1; i >= 0; i--) begin
         if (r_zone_hit[i]) w_sel = ZIDX_W'(i);
      end
   end

   assign w_any     = |r_zone_hit;
   assign w_trk_hit = r_zone_hit[r_trk_zone];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_trk_zone     <= '0;
         r_reached_zone <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_trk_zone <= w_trk_nxt;
         if (w_state_nxt == ST_REACHED && r_state != ST_REACHED)
            r_reached_zone <= w_trk_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_trk_nxt   = r_trk_zone;
      if (clear) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
      end else if (r_eval) begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  w_trk_nxt   = w_sel;
                  w_cnt_nxt   = CNT_ONE;
                  w_state_nxt = (DWELL_SAMPLES == 1) ? ST_REACHED : ST_DWELL;
               end
            end
            ST_DWELL: begin
               if (w_trk_hit) begin
                  if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + CNT_ONE;
                  if (r_cnt == CNT_LAST) w_state_nxt = ST_REACHED;
               end else if (w_any) begin
                  // Tracked zone lost but another one hit: restart the run there.
                  w_trk_nxt = w_sel;
                  w_cnt_nxt = CNT_ONE;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            ST_REACHED: ;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      goal_reached = (r_state == ST_REACHED);
      if (r_state == ST_REACHED) colour = COL_REACHED;
      else if (w_any)            colour = COL_INZONE;
      else                       colour = COL_OUTSIDE;
   end

   assign zone_hit     = r_zone_hit;
   assign reached_zone = r_reached_zone;

endmodule

// File: tb/tb_goal_zone_detector.sv
// Bench for goal_zone_detector: directed scenarios plus randomized samples checked
// against a sample-level dwell model; a second instance covers DWELL_SAMPLES=1.
module tb_goal_zone_detector;

   localparam int CW = 9;
   localparam int NZ = 4;
   localparam int D  = 8;
   localparam int ZW = 2;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            coord_valid = 1'b0;
   logic            clear = 1'b0;
   logic [CW-1:0]   x_cord = '0;
   logic [CW-1:0]   y_cord = '0;
   logic [NZ-1:0]   zone_en = '0;
   logic [NZ*CW-1:0] zone_x_min, zone_x_max, zone_y_min, zone_y_max;
   logic [NZ-1:0]   zone_hit, zone_hit1;
   logic [2:0]      colour, colour1;
   logic            goal_reached, goal_reached1;
   logic [ZW-1:0]   reached_zone, reached_zone1;

   int bx_min[NZ], bx_max[NZ], by_min[NZ], by_max[NZ];

   int errors = 0;
   int checks = 0;

   // Sample-level model: hits of the sample, dwell run bookkeeping, pending evaluation.
   logic [NZ-1:0] m_hit;
   logic [NZ-1:0] m_pend_hit;
   bit            m_pend;
   bit            m_reached;
   int            m_rzone, m_trk, m_cnt;

   always #5 clock = ~clock;

   always_comb begin
      zone_x_min = '0;
      zone_x_max = '0;
      zone_y_min = '0;
      zone_y_max = '0;
      for (int i = 0; i < NZ; i++) begin
         zone_x_min[i*CW +: CW] = CW'(bx_min[i]);
         zone_x_max[i*CW +: CW] = CW'(bx_max[i]);
         zone_y_min[i*CW +: CW] = CW'(by_min[i]);
         zone_y_max[i*CW +: CW] = CW'(by_max[i]);
      end
   end

   goal_zone_detector #(.COORD_W(CW), .NUM_ZONES(NZ), .DWELL_SAMPLES(D), .ZIDX_W(ZW)) dut (
      .clock(clock), .reset(reset), .coord_valid(coord_valid), .x_cord(x_cord), .y_cord(y_cord),
      .zone_en(zone_en), .zone_x_min(zone_x_min), .zone_x_max(zone_x_max),
      .zone_y_min(zone_y_min), .zone_y_max(zone_y_max), .clear(clear),
      .zone_hit(zone_hit), .colour(colour), .goal_reached(goal_reached), .reached_zone(reached_zone));

   goal_zone_detector #(.COORD_W(CW), .NUM_ZONES(NZ), .DWELL_SAMPLES(1), .ZIDX_W(ZW)) dut1 (
      .clock(clock), .reset(reset), .coord_valid(coord_valid), .x_cord(x_cord), .y_cord(y_cord),
      .zone_en(zone_en), .zone_x_min(zone_x_min), .zone_x_max(zone_x_max),
      .zone_y_min(zone_y_min), .zone_y_max(zone_y_max), .clear(clear),
      .zone_hit(zone_hit1), .colour(colour1), .goal_reached(goal_reached1), .reached_zone(reached_zone1));

   function automatic logic [NZ-1:0] ref_hits(input int x, input int y);
      logic [NZ-1:0] h = '0;
      for (int i = 0; i < NZ; i++)
         h[i] = zone_en[i] && x >= bx_min[i] && x <= bx_max[i] && y >= by_min[i] && y <= by_max[i];
      return h;
   endfunction

   function automatic logic [2:0] exp_colour();
      if (m_reached) return 3'b010;
      if (m_hit != 0) return 3'b000;
      return 3'b111;
   endfunction

   task automatic model_reset();
      m_hit = '0; m_pend_hit = '0; m_pend = 0; m_reached = 0;
      m_rzone = 0; m_trk = 0; m_cnt = 0;
   endtask

   task automatic set_zone(input int i, input int x0, input int x1, input int y0, input int y1);
      bx_min[i] = x0; bx_max[i] = x1; by_min[i] = y0; by_max[i] = y1;
   endtask

   // One clock edge with the given inputs; model updated to what is visible after it.
   task automatic drive(input bit v, input int x, input int y, input bit clr);
      logic [NZ-1:0] hv;
      coord_valid = v; x_cord = CW'(x); y_cord = CW'(y); clear = clr;
      hv = ref_hits(x, y);
      @(posedge clock); #1;
      if (clr) begin
         m_reached = 0; m_cnt = 0;
      end else if (m_pend && !m_reached) begin
         if (m_cnt > 0 && m_pend_hit[m_trk]) m_cnt++;
         else if (m_pend_hit != 0) begin
            for (int i = NZ - 1; i >= 0; i--) if (m_pend_hit[i]) m_trk = i;
            m_cnt = 1;
         end else m_cnt = 0;
         if (m_cnt >= D) begin m_reached = 1; m_rzone = m_trk; end
      end
      if (v) m_hit = hv;
      m_pend = v && !clr;
      m_pend_hit = hv;
      coord_valid = 0; clear = 0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1; model_reset();
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (zone_hit !== 4'b0000) begin errors++; $display("FAIL reset_zone_hit got=%b exp=0000", zone_hit); end
      checks++; if (colour !== 3'b111) begin errors++; $display("FAIL reset_colour got=%b exp=111", colour); end
      checks++; if (goal_reached !== 1'b0) begin errors++; $display("FAIL reset_goal got=%b exp=0", goal_reached); end
      checks++; if (reached_zone !== 2'd0) begin errors++; $display("FAIL reset_rzone got=%0d exp=0", reached_zone); end
      @(negedge clock); reset = 1'b0; model_reset();
      @(posedge clock); #1;
   endtask

   task automatic test_dwell();
      for (int s = 1; s <= D + 1; s++) begin
         drive(s <= D, 10, 30, 0);
         checks++; if (zone_hit !== m_hit) begin errors++; $display("FAIL dwell_hit s=%0d got=%b exp=%b", s, zone_hit, m_hit); end
         checks++; if (goal_reached !== m_reached) begin errors++; $display("FAIL dwell_goal s=%0d got=%b exp=%b", s, goal_reached, m_reached); end
         checks++; if (colour !== exp_colour()) begin errors++; $display("FAIL dwell_colour s=%0d got=%b exp=%b", s, colour, exp_colour()); end
      end
      checks++; if (goal_reached !== 1'b1 || reached_zone !== 2'd0) begin
         errors++; $display("FAIL dwell_final goal=%b rzone=%0d exp goal=1 rzone=0", goal_reached, reached_zone); end
      drive(0, 0, 0, 1);
   endtask

   task automatic test_boundary();
      int px[5] = '{5, 20, 4, 21, 10};
      int py[5] = '{15, 45, 15, 30, 46};
      logic [NZ-1:0] eh[5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
      logic [2:0]    ec[5] = '{3'b000, 3'b000, 3'b111, 3'b111, 3'b111};
      for (int k = 0; k < 5; k++) begin
         drive(1, px[k], py[k], 0);
         checks++; if (zone_hit !== eh[k]) begin errors++; $display("FAIL bound_hit (%0d,%0d) got=%b exp=%b", px[k], py[k], zone_hit, eh[k]); end
         checks++; if (colour !== ec[k]) begin errors++; $display("FAIL bound_colour (%0d,%0d) got=%b exp=%b", px[k], py[k], colour, ec[k]); end
      end
   endtask

   task automatic test_leave();
      drive(0, 0, 0, 1);
      for (int s = 0; s < 5 + 1 + D; s++) begin
         if (s == 5) drive(1, 100, 100, 0);
         else drive(1, 10, 30, 0);
         drive(0, 0, 0, 0);
         checks++; if (goal_reached !== m_reached) begin errors++; $display("FAIL leave_goal s=%0d got=%b exp=%b", s, goal_reached, m_reached); end
         checks++; if (goal_reached !== (s == 5 + D)) begin errors++; $display("FAIL leave_when s=%0d got=%b", s, goal_reached); end
      end
   endtask

   task automatic test_overlap();
      set_zone(1, 40, 60, 40, 60);
      set_zone(2, 45, 70, 45, 70);
      zone_en = 4'b0111;
      drive(0, 0, 0, 1);
      for (int s = 0; s < D; s++) drive(1, 50, 50, 0);
      drive(0, 0, 0, 0);
      checks++; if (goal_reached !== 1'b1 || reached_zone !== 2'd1) begin
         errors++; $display("FAIL overlap_z1 goal=%b rzone=%0d exp goal=1 rzone=1", goal_reached, reached_zone); end
      drive(0, 0, 0, 1);
      for (int s = 0; s < 4; s++) drive(1, 50, 50, 0);
      for (int s = 1; s <= D; s++) begin
         drive(1, 65, 65, 0);
         drive(0, 0, 0, 0);
         checks++; if (goal_reached !== (s == D)) begin errors++; $display("FAIL overlap_restart s=%0d got=%b", s, goal_reached); end
         checks++; if (goal_reached !== m_reached) begin errors++; $display("FAIL overlap_model s=%0d got=%b exp=%b", s, goal_reached, m_reached); end
      end
      checks++; if (reached_zone !== 2'd2) begin errors++; $display("FAIL overlap_z2 got=%0d exp=2", reached_zone); end
   endtask

   task automatic test_clear_same();
      checks++; if (goal_reached !== 1'b1) begin errors++; $display("FAIL clr_pre got=%b exp=1", goal_reached); end
      drive(1, 10, 30, 1);
      checks++; if (goal_reached !== 1'b0) begin errors++; $display("FAIL clr_goal got=%b exp=0", goal_reached); end
      checks++; if (colour !== 3'b000) begin errors++; $display("FAIL clr_colour got=%b exp=000", colour); end
      for (int s = 1; s <= D; s++) begin
         drive(1, 10, 30, 0);
         drive(0, 0, 0, 0);
         checks++; if (goal_reached !== (s == D)) begin errors++; $display("FAIL clr_rerun s=%0d got=%b", s, goal_reached); end
      end
      zone_en = 4'b0110;
      drive(0, 0, 0, 1);
      drive(1, 10, 30, 0);
      checks++; if (zone_hit !== 4'b0000) begin errors++; $display("FAIL zone_disabled got=%b exp=0000", zone_hit); end
      checks++; if (colour !== 3'b111) begin errors++; $display("FAIL zone_disabled_col got=%b exp=111", colour); end
      zone_en = 4'b0111;
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 0, 1);
      for (int s = 0; s < 6; s++) drive(1, 10, 30, 0);
      drive(0, 0, 0, 0);
      checks++; if (zone_hit !== 4'b0001 || goal_reached !== 1'b0) begin
         errors++; $display("FAIL mid_pre hit=%b goal=%b exp hit=0001 goal=0", zone_hit, goal_reached); end
      reset = 1'b1; #1;
      checks++; if (zone_hit !== 4'b0000 || colour !== 3'b111) begin
         errors++; $display("FAIL mid_dwell_rst hit=%b colour=%b exp 0000/111", zone_hit, colour); end
      @(negedge clock); reset = 1'b0; model_reset();
      @(posedge clock); #1;
      for (int s = 0; s < D; s++) drive(1, 65, 65, 0);
      drive(0, 0, 0, 0);
      checks++; if (goal_reached !== 1'b1 || reached_zone !== 2'd2) begin
         errors++; $display("FAIL mid_reach goal=%b rzone=%0d exp 1/2", goal_reached, reached_zone); end
      reset = 1'b1; #1;
      checks++; if (goal_reached !== 1'b0 || reached_zone !== 2'd0 || colour !== 3'b111 || zone_hit !== 4'b0000) begin
         errors++; $display("FAIL reached_rst goal=%b rzone=%0d colour=%b hit=%b", goal_reached, reached_zone, colour, zone_hit); end
      @(negedge clock); reset = 1'b0; model_reset();
      @(posedge clock); #1;
   endtask

   task automatic test_dwell1();
      zone_en = 4'b0010;
      drive(1, 50, 50, 0);
      checks++; if (goal_reached1 !== 1'b0 || zone_hit1 !== 4'b0010) begin
         errors++; $display("FAIL d1_first goal=%b hit=%b exp 0/0010", goal_reached1, zone_hit1); end
      drive(0, 0, 0, 0);
      checks++; if (goal_reached1 !== 1'b1 || reached_zone1 !== 2'd1 || colour1 !== 3'b010) begin
         errors++; $display("FAIL d1_reach goal=%b rzone=%0d colour=%b exp 1/1/010", goal_reached1, reached_zone1, colour1); end
      checks++; if (goal_reached !== 1'b0) begin errors++; $display("FAIL d8_not_yet got=%b exp=0", goal_reached); end
      pulse_reset();
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         if (n % 60 == 0) begin
            for (int i = 0; i < NZ; i++)
               set_zone(i, $urandom_range(0, 40), $urandom_range(8, 63), $urandom_range(0, 40), $urandom_range(8, 63));
            zone_en = NZ'($urandom_range(1, 15));
         end
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 24) == 0);
         checks++; if (zone_hit !== m_hit) begin errors++; $display("FAIL rnd_hit n=%0d got=%b exp=%b", n, zone_hit, m_hit); end
         checks++; if (goal_reached !== m_reached) begin errors++; $display("FAIL rnd_goal n=%0d got=%b exp=%b", n, goal_reached, m_reached); end
         checks++; if (colour !== exp_colour()) begin errors++; $display("FAIL rnd_colour n=%0d got=%b exp=%b", n, colour, exp_colour()); end
         checks++; if (reached_zone !== ZW'(m_rzone)) begin errors++; $display("FAIL rnd_rzone n=%0d got=%0d exp=%0d", n, reached_zone, m_rzone); end
      end
   endtask

   initial begin
      for (int i = 0; i < NZ; i++) set_zone(i, 0, 0, 0, 0);
      set_zone(0, 5, 20, 15, 45);
      zone_en = 4'b0001;
      model_reset();
      test_reset();
      test_dwell();
      test_boundary();
      test_leave();
      test_overlap();
      test_clear_same();
      test_reset_mid();
      test_dwell1();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
